// File: rtl/sdram_sprite_writer_if.sv
// Bundles the pixel stream, transfer control and Avalon-MM write bus of
// sdram_sprite_writer. The master modport is the writer side; the slave
// modport is the loader / SDRAM side that drives the control and stream inputs.
interface sdram_sprite_writer_if #(
  parameter int ADDR_W = 25,
  parameter int CNT_W  = 20
);
  // transfer control
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              done;

  // pixel stream
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;

  // Avalon-MM write master toward the SDRAM slave
  logic [ADDR_W-1:0] sdram_address;
  logic [3:0]        sdram_byteenable_n;
  logic              sdram_chipselect;
  logic [31:0]       sdram_writedata;
  logic              sdram_write_n;
  logic              sdram_read_n;
  logic              sdram_waitrequest;

  modport master (
    input  start, base_addr, word_count, in_data, in_valid, sdram_waitrequest,
    output in_ready, busy, done,
    output sdram_address, sdram_byteenable_n, sdram_chipselect,
    output sdram_writedata, sdram_write_n, sdram_read_n
  );

  modport slave (
    output start, base_addr, word_count, in_data, in_valid, sdram_waitrequest,
    input  in_ready, busy, done,
    input  sdram_address, sdram_byteenable_n, sdram_chipselect,
    input  sdram_writedata, sdram_write_n, sdram_read_n
  );
endinterface

// File: rtl/sdram_sprite_writer.sv
// Streams 32-bit sprite/background words into SDRAM via single-word Avalon-MM
// writes to consecutive addresses from a programmed base. Words pass through a
// small FIFO whose head is presented on registered bus outputs; the head word
// stays counted in the FIFO until the slave accepts it.
module sdram_sprite_writer #(
  parameter int ADDR_W     = 25,
  parameter int CNT_W      = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sdram_sprite_writer_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  issued_reg;
  logic [CNT_W-1:0]  taken_reg;

  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [OCC_W-1:0]  occ_reg;

  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       data_reg;
  logic              write_n_reg;
  logic              cs_reg;
  logic [3:0]        be_n_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              start_ok;
  logic              in_ready_int;
  logic              push;
  logic              accept;
  logic [OCC_W-1:0]  remain;
  logic              show;
  logic [PTR_W-1:0]  rd_sel;
  logic [ADDR_W-1:0] addr_next;

  // Handshakes, FIFO head selection and the address of the word to present.
  always_comb begin
    start_ok     = (state_reg == IDLE) && bus.start;
    in_ready_int = (state_reg == WRITE) && (occ_reg != OCC_W'(FIFO_DEPTH)) &&
                   (taken_reg < count_reg);
    push         = bus.in_valid && in_ready_int;
    accept       = !write_n_reg && !bus.sdram_waitrequest;
    // Words already buffered before this edge that survive the pop; a word
    // pushed on this same edge reaches the bus one cycle later.
    remain       = occ_reg - OCC_W'(accept);
    show         = (state_reg == WRITE) && (remain != '0);
    rd_sel       = rd_ptr_reg + PTR_W'(accept);
    addr_next    = base_reg + ADDR_W'(issued_reg) + ADDR_W'(accept);
  end

  // Next-state logic: IDLE -> WRITE (or straight to DONE on a zero count) -> DONE -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = (bus.word_count == '0) ? DONE : WRITE;
      WRITE:   if (issued_reg == count_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus the busy/done flags derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
    end
  end

  // Transfer parameters and the taken/issued word counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg   <= '0;
      count_reg  <= '0;
      issued_reg <= '0;
      taken_reg  <= '0;
    end else if (start_ok) begin
      base_reg   <= bus.base_addr;
      count_reg  <= bus.word_count;
      issued_reg <= '0;
      taken_reg  <= '0;
    end else begin
      if (push)   taken_reg  <= taken_reg + 1'b1;
      if (accept) issued_reg <= issued_reg + 1'b1;
    end
  end

  // FIFO storage: plain array without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= bus.in_data;
  end

  // FIFO pointers and occupancy; reset flushes any buffered words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push);
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(accept);
      occ_reg    <= occ_reg + OCC_W'(push) - OCC_W'(accept);
    end
  end

  // Registered bus outputs; address and data keep their last values when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg    <= '0;
      data_reg    <= '0;
      write_n_reg <= 1'b1;
      cs_reg      <= 1'b0;
      be_n_reg    <= 4'b1111;
    end else begin
      write_n_reg <= !show;
      cs_reg      <= show;
      be_n_reg    <= show ? 4'b0000 : 4'b1111;
      if (show) begin
        addr_reg <= addr_next;
        data_reg <= mem[rd_sel];
      end
    end
  end

  assign bus.in_ready           = in_ready_int;
  assign bus.busy               = busy_reg;
  assign bus.done               = done_reg;
  assign bus.sdram_address      = addr_reg;
  assign bus.sdram_writedata    = data_reg;
  assign bus.sdram_write_n      = write_n_reg;
  assign bus.sdram_chipselect   = cs_reg;
  assign bus.sdram_byteenable_n = be_n_reg;
  assign bus.sdram_read_n       = 1'b1;

endmodule

// File: tb/tb_sdram_sprite_writer.sv
// Directed testbench for sdram_sprite_writer: one task per scenario, with a
// bus observer logging every accepted SDRAM write and every stream handshake.
module tb_sdram_sprite_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sdram_sprite_writer_if #(.ADDR_W(25), .CNT_W(20)) bus ();

  sdram_sprite_writer #(.ADDR_W(25), .CNT_W(20), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // observer state
  int          cyc = 0;
  logic [24:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          wr_low_cnt = 0;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      if (!bus.sdram_write_n) begin
        wr_low_cnt++;
        if (!bus.sdram_waitrequest) begin
          log_addr.push_back(bus.sdram_address);
          log_data.push_back(bus.sdram_writedata);
          log_cyc.push_back(cyc);
        end
      end
      if (bus.in_valid && bus.in_ready) hs_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic do_start(input logic [24:0] base, input logic [19:0] count);
    bus.base_addr  = base;
    bus.word_count = count;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Offer words first, first+1, ... until n handshakes or the cycle budget runs out.
  task automatic feed(input int n, input logic [31:0] first, output int sent);
    logic rdy;
    sent = 0;
    for (int c = 0; c < 200 && sent < n; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = first + 32'(sent);
      rdy = bus.in_ready;
      tick();
      if (rdy) sent++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (bus.done) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: in_ready/busy/done=%b expected 000", {bus.in_ready, bus.busy, bus.done});
    end
    n_checks++;
    if ({bus.sdram_write_n, bus.sdram_read_n, bus.sdram_chipselect, bus.sdram_byteenable_n} !== 7'b1101111) begin
      n_fail++;
      $display("FAIL reset_bus_ctl: wn/rn/cs/be_n=%b expected 1101111",
               {bus.sdram_write_n, bus.sdram_read_n, bus.sdram_chipselect, bus.sdram_byteenable_n});
    end
    n_checks++;
    if (bus.sdram_address !== 25'h0 || bus.sdram_writedata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr_data: addr=%h data=%h expected 0/0", bus.sdram_address, bus.sdram_writedata);
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic;
    int sent;
    bit ok;
    int d0;
    clear_log();
    d0 = done_cnt;
    do_start(25'h00100, 20'd4);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_start: busy=%b in_ready=%b expected 1/1", bus.busy, bus.in_ready);
    end
    feed(4, 32'hA0, sent);
    wait_done(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done_timeout: done=0 expected 1");
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_done: done=%b busy=%b expected 0/0", bus.done, bus.busy);
    end
    n_checks++;
    if (log_addr.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count: writes=%0d expected 4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (log_addr[i] !== 25'h00100 + 25'(i) || log_data[i] !== 32'hA0 + 32'(i) ||
            log_cyc[i] != log_cyc[0] + i) begin
          n_fail++;
          $display("FAIL basic_write%0d: addr=%h data=%h cyc=%0d expected %h %h %0d", i,
                   log_addr[i], log_data[i], log_cyc[i], 25'h00100 + 25'(i), 32'hA0 + 32'(i), log_cyc[0] + i);
        end
      end
      n_checks++;
      if (done_cyc != log_cyc[3] + 2) begin
        n_fail++;
        $display("FAIL basic_done_timing: done seen at %0d expected %0d", done_cyc, log_cyc[3] + 2);
      end
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL basic_done_pulses: pulses=%0d expected 1", done_cnt - d0);
    end
    $display("test_basic: %0d writes", log_addr.size());
  endtask

  task automatic test_stall;
    int sent;
    bit ok;
    bit found;
    bit held;
    clear_log();
    do_start(25'h00100, 20'd3);
    feed(3, 32'hB0, sent);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ready_after_count: in_ready=%b expected 0", bus.in_ready);
    end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (!bus.sdram_write_n && bus.sdram_address == 25'h00101) found = 1'b1;
      else tick();
    end
    bus.sdram_waitrequest = 1'b1;
    held = found;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.sdram_write_n !== 1'b0 || bus.sdram_address !== 25'h00101 || bus.sdram_writedata !== 32'hB1)
        held = 1'b0;
    end
    n_checks++;
    if (!held) begin
      n_fail++;
      $display("FAIL stall_hold: wn=%b addr=%h data=%h expected 0 00101 000000b1",
               bus.sdram_write_n, bus.sdram_address, bus.sdram_writedata);
    end
    bus.sdram_waitrequest = 1'b0;
    wait_done(ok);
    tick();
    n_checks++;
    if (!ok || log_addr.size() != 3) begin
      n_fail++;
      $display("FAIL stall_count: done=%b writes=%0d expected 1/3", ok, log_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (log_addr[i] !== 25'h00100 + 25'(i) || log_data[i] !== 32'hB0 + 32'(i)) begin
          n_fail++;
          $display("FAIL stall_write%0d: addr=%h data=%h expected %h %h", i,
                   log_addr[i], log_data[i], 25'h00100 + 25'(i), 32'hB0 + 32'(i));
        end
      end
    end
    $display("test_stall: %0d writes", log_addr.size());
  endtask

  task automatic test_fifo_full;
    int sent;
    int more;
    bit ok;
    logic rdy;
    clear_log();
    bus.sdram_waitrequest = 1'b1;
    do_start(25'h00200, 20'd8);
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hC0 + 32'(sent);
      rdy = bus.in_ready;
      tick();
      if (rdy) sent++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (sent != 4 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: handshakes=%0d in_ready=%b expected 4/0", sent, bus.in_ready);
    end
    n_checks++;
    if (bus.sdram_write_n !== 1'b0 || bus.sdram_address !== 25'h00200 || bus.sdram_writedata !== 32'hC0) begin
      n_fail++;
      $display("FAIL full_head: wn=%b addr=%h data=%h expected 0 00200 000000c0",
               bus.sdram_write_n, bus.sdram_address, bus.sdram_writedata);
    end
    bus.sdram_waitrequest = 1'b0;
    feed(4, 32'hC4, more);
    wait_done(ok);
    tick();
    n_checks++;
    if (!ok || log_addr.size() != 8) begin
      n_fail++;
      $display("FAIL full_count: done=%b writes=%0d expected 1/8", ok, log_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (log_addr[i] !== 25'h00200 + 25'(i) || log_data[i] !== 32'hC0 + 32'(i)) begin
          n_fail++;
          $display("FAIL full_write%0d: addr=%h data=%h expected %h %h", i,
                   log_addr[i], log_data[i], 25'h00200 + 25'(i), 32'hC0 + 32'(i));
        end
      end
    end
    $display("test_fifo_full: %0d writes", log_addr.size());
  endtask

  task automatic test_overfeed;
    int h0;
    bit ok;
    clear_log();
    h0 = hs_cnt;
    do_start(25'h00500, 20'd2);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h50 + 32'(c);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_done(ok);
    tick();
    n_checks++;
    if (hs_cnt - h0 != 2 || log_addr.size() != 2) begin
      n_fail++;
      $display("FAIL overfeed_count: handshakes=%0d writes=%0d expected 2/2", hs_cnt - h0, log_addr.size());
    end
    $display("test_overfeed: %0d handshakes", hs_cnt - h0);
  endtask

  task automatic test_zero;
    int w0;
    w0 = wr_low_cnt;
    do_start(25'h00700, 20'd0);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.sdram_write_n !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b wn=%b expected 1/1/1", bus.done, bus.busy, bus.sdram_write_n);
    end
    tick();
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || wr_low_cnt != w0) begin
      n_fail++;
      $display("FAIL zero_after: done=%b busy=%b write cycles=%0d expected 0/0/0",
               bus.done, bus.busy, wr_low_cnt - w0);
    end
    $display("test_zero: done");
  endtask

  task automatic test_wrap;
    int sent;
    bit ok;
    logic [24:0] exp_addr [4];
    exp_addr[0] = 25'h1FFFFFE;
    exp_addr[1] = 25'h1FFFFFF;
    exp_addr[2] = 25'h0000000;
    exp_addr[3] = 25'h0000001;
    clear_log();
    do_start(25'h1FFFFFE, 20'd4);
    feed(4, 32'h70, sent);
    wait_done(ok);
    tick();
    n_checks++;
    if (!ok || log_addr.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_count: done=%b writes=%0d expected 1/4", ok, log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== 32'h70 + 32'(i)) begin
          n_fail++;
          $display("FAIL wrap_write%0d: addr=%h data=%h expected %h %h", i,
                   log_addr[i], log_data[i], exp_addr[i], 32'h70 + 32'(i));
        end
      end
    end
    $display("test_wrap: %0d writes", log_addr.size());
  endtask

  task automatic test_reset_mid;
    int sent;
    int c;
    bit ok;
    clear_log();
    do_start(25'h00300, 20'd8);
    sent = 0;
    c = 0;
    while (log_addr.size() < 2 && c < 50) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hD0 + 32'(c);
      tick();
      c++;
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.done, bus.sdram_write_n, bus.sdram_read_n,
         bus.sdram_chipselect, bus.sdram_byteenable_n} !== 10'b0001101111 ||
        bus.sdram_address !== 25'h0 || bus.sdram_writedata !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_values: rdy/busy/done/wn/rn/cs/be_n=%b addr=%h data=%h expected 0001101111 0 0",
               {bus.in_ready, bus.busy, bus.done, bus.sdram_write_n, bus.sdram_read_n,
                bus.sdram_chipselect, bus.sdram_byteenable_n}, bus.sdram_address, bus.sdram_writedata);
    end
    tick();
    #2 rst = 1'b0;
    tick();
    clear_log();
    do_start(25'h00400, 20'd1);
    feed(1, 32'hE0, sent);
    wait_done(ok);
    tick();
    tick();
    n_checks++;
    if (!ok || log_addr.size() != 1) begin
      n_fail++;
      $display("FAIL midreset_restart_count: done=%b writes=%0d expected 1/1", ok, log_addr.size());
    end else begin
      n_checks++;
      if (log_addr[0] !== 25'h00400 || log_data[0] !== 32'hE0) begin
        n_fail++;
        $display("FAIL midreset_restart_word: addr=%h data=%h expected 00400 000000e0", log_addr[0], log_data[0]);
      end
    end
    $display("test_reset_mid: restart wrote %0d words", log_addr.size());
  endtask

  initial begin
    bus.start             = 1'b0;
    bus.base_addr         = '0;
    bus.word_count        = '0;
    bus.in_data           = '0;
    bus.in_valid          = 1'b0;
    bus.sdram_waitrequest = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_stall();
    test_fifo_full();
    test_overfeed();
    test_zero();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
